// File: rtl/ccu_snoop_sequencer.sv
// Coherent snoop sequencer: broadcasts one snoop to all non-initiating cores,
// merges their CR responses, forwards the CD line of the lowest-index data
// provider (draining any others) and returns a merged result.
module ccu_snoop_sequencer #(
    parameter int unsigned NB_CORES  = 2,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdxWidth  = (NB_CORES > 1) ? $clog2(NB_CORES) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [AddrWidth-1:0]            req_addr_i,
    input  logic [3:0]                      req_snoop_i,
    input  logic [IdxWidth-1:0]             req_initiator_i,
    output logic [NB_CORES-1:0]             ac_valid_o,
    input  logic [NB_CORES-1:0]             ac_ready_i,
    output logic [AddrWidth-1:0]            ac_addr_o,
    output logic [3:0]                      ac_snoop_o,
    input  logic [NB_CORES-1:0]             cr_valid_i,
    output logic [NB_CORES-1:0]             cr_ready_o,
    input  logic [NB_CORES*5-1:0]           cr_resp_i,
    input  logic [NB_CORES-1:0]             cd_valid_i,
    output logic [NB_CORES-1:0]             cd_ready_o,
    input  logic [NB_CORES*DataWidth-1:0]   cd_data_i,
    input  logic [NB_CORES-1:0]             cd_last_i,
    output logic                            data_valid_o,
    input  logic                            data_ready_i,
    output logic [DataWidth-1:0]            data_o,
    output logic                            data_last_o,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            rsp_data_o,
    output logic                            rsp_shared_o,
    output logic                            rsp_dirty_o,
    output logic                            rsp_error_o
);

    typedef enum logic [1:0] {IDLE, SNOOP, DATA, RESP} state_t;

    state_t                 state;
    logic [AddrWidth-1:0]   addr;
    logic [3:0]             snoop;
    logic [NB_CORES-1:0]    target;
    logic [NB_CORES-1:0]    ac_done;
    logic [NB_CORES-1:0]    cr_done;
    logic [NB_CORES-1:0]    data_mask;
    logic [NB_CORES-1:0]    pass_dirty;
    logic [IdxWidth-1:0]    sel;
    logic                   shared;
    logic                   error;
    logic                   dirty;
    logic                   fwd_data;

    logic [NB_CORES-1:0]    ac_hs;
    logic [NB_CORES-1:0]    cr_hs;
    logic [NB_CORES-1:0]    cd_last_hs;
    logic [NB_CORES-1:0]    cr_done_nx;
    logic [NB_CORES-1:0]    data_mask_nx;
    logic [NB_CORES-1:0]    pass_dirty_nx;
    logic [NB_CORES-1:0]    unused_was_unique;
    logic [IdxWidth-1:0]    sel_nx;
    logic                   sel_found;
    logic                   shared_hs;
    logic                   error_hs;

    assign req_ready_o  = (state == IDLE);
    assign rsp_valid_o  = (state == RESP);
    assign ac_addr_o    = addr;
    assign ac_snoop_o   = snoop;
    assign rsp_data_o   = fwd_data;
    assign rsp_shared_o = shared;
    assign rsp_dirty_o  = dirty;
    assign rsp_error_o  = error;

    // Per-core channel handshakes, CR merge and forwarding mux for the current state.
    always_comb begin
        ac_valid_o        = '0;
        cr_ready_o        = '0;
        cd_ready_o        = '0;
        shared_hs         = 1'b0;
        error_hs          = 1'b0;
        data_mask_nx      = data_mask;
        pass_dirty_nx     = pass_dirty;
        unused_was_unique = '0;
        sel_nx            = '0;
        sel_found         = 1'b0;

        if (state == SNOOP) begin
            ac_valid_o = target & ~ac_done;
            cr_ready_o = target & ac_done & ~cr_done;
        end
        ac_hs      = ac_valid_o & ac_ready_i;
        cr_hs      = cr_ready_o & cr_valid_i;
        cr_done_nx = cr_done | cr_hs;

        for (int unsigned i = 0; i < NB_CORES; i++) begin
            unused_was_unique[i] = cr_resp_i[i*5+4];
            if (cr_hs[i]) begin
                shared_hs        = shared_hs | cr_resp_i[i*5+3];
                error_hs         = error_hs  | cr_resp_i[i*5+1];
                pass_dirty_nx[i] = cr_resp_i[i*5+2];
                data_mask_nx[i]  = cr_resp_i[i*5];
            end
        end

        for (int unsigned i = 0; i < NB_CORES; i++) begin
            if (!sel_found && data_mask_nx[i]) begin
                sel_nx    = IdxWidth'(i);
                sel_found = 1'b1;
            end
        end

        if (state == DATA) begin
            for (int unsigned i = 0; i < NB_CORES; i++) begin
                if (data_mask[i]) begin
                    cd_ready_o[i] = (sel == IdxWidth'(i)) ? data_ready_i : 1'b1;
                end
            end
        end
        cd_last_hs = cd_ready_o & cd_valid_i & cd_last_i;

        data_valid_o = (state == DATA) && data_mask[sel] && cd_valid_i[sel];
        data_o       = cd_data_i[sel*DataWidth +: DataWidth];
        data_last_o  = cd_last_i[sel];
    end

    // Transaction FSM with registered masks and merged response flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr       <= '0;
            snoop      <= '0;
            target     <= '0;
            ac_done    <= '0;
            cr_done    <= '0;
            data_mask  <= '0;
            pass_dirty <= '0;
            sel        <= '0;
            shared     <= 1'b0;
            error      <= 1'b0;
            dirty      <= 1'b0;
            fwd_data   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr       <= req_addr_i;
                        snoop      <= req_snoop_i;
                        for (int unsigned i = 0; i < NB_CORES; i++) begin
                            target[i] <= (req_initiator_i != IdxWidth'(i));
                        end
                        ac_done    <= '0;
                        cr_done    <= '0;
                        data_mask  <= '0;
                        pass_dirty <= '0;
                        shared     <= 1'b0;
                        error      <= 1'b0;
                        dirty      <= 1'b0;
                        fwd_data   <= 1'b0;
                        state      <= SNOOP;
                    end
                end
                SNOOP: begin
                    ac_done    <= ac_done | ac_hs;
                    cr_done    <= cr_done_nx;
                    data_mask  <= data_mask_nx;
                    pass_dirty <= pass_dirty_nx;
                    shared     <= shared | shared_hs;
                    error      <= error | error_hs;
                    // Selection uses this cycle's CR results so the last responder counts.
                    if ((cr_done_nx & target) == target) begin
                        if (data_mask_nx == '0) begin
                            state <= RESP;
                        end else begin
                            sel   <= sel_nx;
                            dirty <= pass_dirty_nx[sel_nx];
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    data_mask <= data_mask & ~cd_last_hs;
                    if ((data_mask & ~cd_last_hs) == '0) begin
                        fwd_data <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_snoop_sequencer.sv
// Scoreboard bench for ccu_snoop_sequencer with four snooped cores: the
// stimulus pushes expected beats/results, a negedge monitor pops and compares.
module tb_ccu_snoop_sequencer;

    localparam int NC = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 2;

    logic              clk_i;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [AW-1:0]     req_addr_i;
    logic [3:0]        req_snoop_i;
    logic [IW-1:0]     req_initiator_i;
    logic [NC-1:0]     ac_valid_o;
    logic [NC-1:0]     ac_ready_i;
    logic [AW-1:0]     ac_addr_o;
    logic [3:0]        ac_snoop_o;
    logic [NC-1:0]     cr_valid_i;
    logic [NC-1:0]     cr_ready_o;
    logic [NC*5-1:0]   cr_resp_i;
    logic [NC-1:0]     cd_valid_i;
    logic [NC-1:0]     cd_ready_o;
    logic [NC*DW-1:0]  cd_data_i;
    logic [NC-1:0]     cd_last_i;
    logic              data_valid_o;
    logic              data_ready_i;
    logic [DW-1:0]     data_o;
    logic              data_last_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_data_o;
    logic              rsp_shared_o;
    logic              rsp_dirty_o;
    logic              rsp_error_o;

    ccu_snoop_sequencer #(
        .NB_CORES (NC),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_snoop_i    (req_snoop_i),
        .req_initiator_i(req_initiator_i),
        .ac_valid_o     (ac_valid_o),
        .ac_ready_i     (ac_ready_i),
        .ac_addr_o      (ac_addr_o),
        .ac_snoop_o     (ac_snoop_o),
        .cr_valid_i     (cr_valid_i),
        .cr_ready_o     (cr_ready_o),
        .cr_resp_i      (cr_resp_i),
        .cd_valid_i     (cd_valid_i),
        .cd_ready_o     (cd_ready_o),
        .cd_data_i      (cd_data_i),
        .cd_last_i      (cd_last_i),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .data_o         (data_o),
        .data_last_o    (data_last_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_shared_o   (rsp_shared_o),
        .rsp_dirty_o    (rsp_dirty_o),
        .rsp_error_o    (rsp_error_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int beats_seen = 0;
    int rsp_first  = 0;
    int t_acc      = 0;
    logic rsp_prev = 1'b0;

    // Scoreboard queues: beat = {last, data}; result = {data, shared, dirty, error}
    logic [64:0] beat_q[$];
    logic [3:0]  rsp_q[$];

    // Core responder configuration
    int          ac_dly [NC];
    int          ac_wait[NC];
    logic [4:0]  cr_cfg [NC];
    logic [63:0] cd_q   [NC][$];
    logic        cr_pend[NC];
    logic        cd_en  [NC];
    logic [NC-1:0] ac_hs, cr_hs, cd_hs;
    logic        rst_seen;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            cycle++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Core models: AC ready after a per-core delay, CR offered while AC is
    // presented (exercises cr_ready gating), CD beats after the CR handshake.
    initial begin
        ac_ready_i = '0;
        cr_valid_i = '0;
        cr_resp_i  = '0;
        cd_valid_i = '0;
        cd_data_i  = '0;
        cd_last_i  = '0;
        for (int c = 0; c < NC; c++) begin
            ac_wait[c] = 0;
            cr_pend[c] = 1'b0;
            cd_en[c]   = 1'b0;
        end
        forever begin
            @(negedge clk_i);
            ac_hs    = ac_valid_o & ac_ready_i;
            cr_hs    = cr_valid_i & cr_ready_o;
            cd_hs    = cd_valid_i & cd_ready_o;
            rst_seen = rst_i;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < NC; c++) begin
                if (rst_seen) begin
                    ac_ready_i[c] = 1'b0;
                    ac_wait[c]    = 0;
                    cr_pend[c]    = 1'b0;
                    cd_en[c]      = 1'b0;
                    cd_q[c].delete();
                end else begin
                    if (cd_hs[c] && cd_q[c].size() > 0) void'(cd_q[c].pop_front());
                    if (cr_hs[c]) begin
                        cr_pend[c] = 1'b0;
                        if (cr_cfg[c][0]) cd_en[c] = 1'b1;
                    end
                    if (ac_valid_o[c]) begin
                        cr_pend[c]    = 1'b1;
                        ac_ready_i[c] = (ac_wait[c] >= ac_dly[c]);
                        ac_wait[c]++;
                    end else begin
                        ac_ready_i[c] = 1'b0;
                        ac_wait[c]    = 0;
                    end
                end
                cr_valid_i[c]        = cr_pend[c];
                cr_resp_i[c*5 +: 5]  = cr_cfg[c];
                cd_valid_i[c]        = cd_en[c] && (cd_q[c].size() > 0);
                cd_data_i[c*DW +: DW] = (cd_q[c].size() > 0) ? cd_q[c][0] : 64'h0;
                cd_last_i[c]         = (cd_q[c].size() == 1);
            end
        end
    end

    // Monitor: compares every forwarded beat and every presented result cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                rsp_prev = 1'b0;
            end else begin
                if (data_valid_o && data_ready_i) begin
                    beats_seen++;
                    chk("beat_expected", beat_q.size() != 0, 1);
                    if (beat_q.size() != 0) chk("beat", {data_last_o, data_o}, beat_q.pop_front());
                end
                if (rsp_valid_o) begin
                    if (!rsp_prev) rsp_first = cycle;
                    chk("rsp_expected", rsp_q.size() != 0, 1);
                    if (rsp_q.size() != 0) begin
                        chk("rsp", {rsp_data_o, rsp_shared_o, rsp_dirty_o, rsp_error_o}, rsp_q[0]);
                        if (rsp_ready_i) void'(rsp_q.pop_front());
                    end
                end
                rsp_prev = rsp_valid_o && !rsp_ready_i;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic reset_cfg();
        for (int c = 0; c < NC; c++) begin
            ac_dly[c] = 0;
            cr_cfg[c] = 5'b0;
            cd_en[c]  = 1'b0;
            cd_q[c].delete();
        end
    endtask

    task automatic send(input logic [IW-1:0] ini, input logic [AW-1:0] a, input logic [3:0] s);
        req_initiator_i = ini;
        req_addr_i      = a;
        req_snoop_i     = s;
        req_valid_i     = 1'b1;
        t_acc           = cycle;
        cyc();
        req_valid_i     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(req_ready_o && beat_q.size() == 0 && rsp_q.size() == 0) && n < 300) begin
            cyc();
            n++;
        end
        chk({name, "_done"}, n < 300, 1);
    endtask

    initial begin
        int n;
        int hi;
        int b0;
        logic bad;

        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        req_snoop_i     = '0;
        req_initiator_i = '0;
        data_ready_i    = 1'b1;
        rsp_ready_i     = 1'b1;
        reset_cfg();
        repeat (3) cyc();
        chk("reset_state",
            {req_ready_o, rsp_valid_o, data_valid_o, ac_valid_o, cr_ready_o, cd_ready_o,
             rsp_data_o, rsp_shared_o, rsp_dirty_o, rsp_error_o},
            {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0});
        rst_i = 1'b0;
        cyc();

        // 1: no data, minimum latency
        reset_cfg();
        rsp_q.push_back(4'b0000);
        send(2'd0, 64'h8000_0040, 4'b0001);
        chk("t1_ac_mask", ac_valid_o, 4'b1110);
        chk("t1_ac_addr", ac_addr_o, 64'h8000_0040);
        chk("t1_ac_snoop", ac_snoop_o, 4'b0001);
        chk("t1_cr_not_yet", cr_ready_o, 4'b0000);
        chk("t1_req_busy", req_ready_o, 0);
        wait_done("t1");
        chk("t1_rsp_latency", rsp_first - t_acc, 3);

        // 2: core1 shared + two beats
        reset_cfg();
        cr_cfg[1] = 5'b01001;
        cd_q[1].push_back(64'hAAAA_AAAA_AAAA_AAAA);
        cd_q[1].push_back(64'hBBBB_BBBB_BBBB_BBBB);
        beat_q.push_back({1'b0, 64'hAAAA_AAAA_AAAA_AAAA});
        beat_q.push_back({1'b1, 64'hBBBB_BBBB_BBBB_BBBB});
        rsp_q.push_back(4'b1100);
        send(2'd0, 64'h8000_0080, 4'b0111);
        wait_done("t2");

        // 3: two providers, lowest index forwarded, dirty one drained
        reset_cfg();
        cr_cfg[0] = 5'b00001;
        cr_cfg[3] = 5'b00101;
        cd_q[0].push_back(64'h1111_1111_1111_1111);
        cd_q[0].push_back(64'h2222_2222_2222_2222);
        cd_q[3].push_back(64'h3333_3333_3333_3333);
        cd_q[3].push_back(64'h4444_4444_4444_4444);
        cd_q[3].push_back(64'h5555_5555_5555_5555);
        beat_q.push_back({1'b0, 64'h1111_1111_1111_1111});
        beat_q.push_back({1'b1, 64'h2222_2222_2222_2222});
        rsp_q.push_back(4'b1000);
        send(2'd2, 64'h0000_1000, 4'b1000);
        chk("t3_ac_mask", ac_valid_o, 4'b1011);
        wait_done("t3");
        chk("t3_core3_drained", cd_q[3].size(), 0);

        // 4: data and response back-pressure
        reset_cfg();
        cr_cfg[1] = 5'b00111;
        for (int i = 1; i <= 4; i++) begin
            cd_q[1].push_back(64'h4444_0000_0000_0000 + 64'(i));
            beat_q.push_back({(i == 4), 64'h4444_0000_0000_0000 + 64'(i)});
        end
        rsp_q.push_back(4'b1011);
        rsp_ready_i = 1'b0;
        b0 = beats_seen;
        send(2'd3, 64'h0000_2040, 4'b0001);
        n = 0;
        while (beats_seen < b0 + 1 && n < 100) begin
            cyc();
            n++;
        end
        chk("t4_first_beat", n < 100, 1);
        data_ready_i = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            #1;
            if (cd_ready_o[1]) bad = 1'b1;
            cyc();
        end
        chk("t4_cd_ready_stalled", bad, 0);
        chk("t4_beats_during_stall", beats_seen, b0 + 1);
        data_ready_i = 1'b1;
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            cyc();
            n++;
        end
        chk("t4_rsp_seen", n < 100, 1);
        repeat (4) cyc();
        chk("t4_rsp_held", rsp_valid_o, 1);
        rsp_ready_i = 1'b1;
        wait_done("t4");

        // 5: delayed AC on core3, error from core1
        reset_cfg();
        ac_dly[3] = 10;
        cr_cfg[1] = 5'b00010;
        rsp_q.push_back(4'b0001);
        send(2'd0, 64'h0000_3000, 4'b0001);
        n = 0;
        hi = 0;
        bad = 1'b0;
        while (ac_valid_o[3] && n < 50) begin
            if (cr_ready_o[3]) bad = 1'b1;
            if (n == 1) chk("t5_ac_drop", ac_valid_o, 4'b1000);
            hi++;
            n++;
            cyc();
        end
        chk("t5_ac3_cycles", hi, 11);
        chk("t5_cr3_gated", bad, 0);
        chk("t5_cr3_open", cr_ready_o[3], 1);
        wait_done("t5");

        // 6: reset in DATA aborts, next request completes
        reset_cfg();
        cr_cfg[1] = 5'b00001;
        for (int i = 1; i <= 6; i++) begin
            cd_q[1].push_back(64'h6666_0000_0000_0000 + 64'(i));
            beat_q.push_back({(i == 6), 64'h6666_0000_0000_0000 + 64'(i)});
        end
        rsp_q.push_back(4'b1000);
        b0 = beats_seen;
        send(2'd0, 64'h0000_4000, 4'b0001);
        n = 0;
        while (beats_seen < b0 + 2 && n < 100) begin
            cyc();
            n++;
        end
        chk("t6_in_data", n < 100, 1);
        data_ready_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        chk("t6_after_reset",
            {req_ready_o, rsp_valid_o, data_valid_o, ac_valid_o, cr_ready_o, cd_ready_o},
            {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0});
        rst_i = 1'b0;
        data_ready_i = 1'b1;
        beat_q.delete();
        rsp_q.delete();
        b0 = beats_seen;
        repeat (5) cyc();
        chk("t6_no_beats_after_reset", beats_seen, b0);
        reset_cfg();
        cr_cfg[0] = 5'b01001;
        cd_q[0].push_back(64'hCAFE_F00D_1234_5678);
        beat_q.push_back({1'b1, 64'hCAFE_F00D_1234_5678});
        rsp_q.push_back(4'b1100);
        send(2'd1, 64'h0000_5000, 4'b0001);
        chk("t6_ac_mask", ac_valid_o, 4'b1101);
        wait_done("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
